// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: NUM_SRC result requesters onto one registered broadcast bus.
// Grants are combinational. The winner is broadcast on the following clock edge.
module cdb_arbiter #(
  parameter int NUM_SRC      = 4,
  parameter int DATA_W       = 40,
  parameter int MODE         = 0,
  parameter int STARVE_LIMIT = 8,
  localparam int SRC_W       = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [NUM_SRC-1:0]        req,
  input  logic [NUM_SRC*DATA_W-1:0] data,
  output logic [NUM_SRC-1:0]        gnt,
  output logic                      cdb_valid,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [SRC_W-1:0]          cdb_src
);

  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]   age_cnt [NUM_SRC];
  logic [NUM_SRC-1:0] aged;
  logic [SRC_W-1:0]   ptr;
  logic [SRC_W-1:0]   win_idx;
  logic               any_gnt;
  logic [DATA_W-1:0]  sel_data;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      aged[i] = (STARVE_LIMIT != 0) && (MODE == 0) && (age_cnt[i] == LIMIT);
    end
  end

  always_comb begin
    int j;
    logic [NUM_SRC-1:0] cand;
    any_gnt = 1'b0;
    win_idx = '0;
    gnt     = '0;
    j       = 0;
    cand    = '0;
    if (rst_n && !flush) begin
      if (MODE == 1) begin
        // Rotating search starting at ptr, wrapping at NUM_SRC (not at 2**SRC_W).
        for (int k = 0; k < NUM_SRC; k++) begin
          j = int'(ptr) + k;
          if (j >= NUM_SRC) j = j - NUM_SRC;
          if (!any_gnt && req[j]) begin
            any_gnt = 1'b1;
            win_idx = SRC_W'(j);
          end
        end
      end else begin
        cand = ((req & aged) != '0) ? (req & aged) : req;
        for (int i = 0; i < NUM_SRC; i++) begin
          if (!any_gnt && cand[i]) begin
            any_gnt = 1'b1;
            win_idx = SRC_W'(i);
          end
        end
      end
      if (any_gnt) gnt[win_idx] = 1'b1;
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt[i]) sel_data = data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) age_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (MODE != 0 || STARVE_LIMIT == 0 || flush || !req[i] || gnt[i]) begin
          age_cnt[i] <= '0;
        end else if (age_cnt[i] != LIMIT) begin
          age_cnt[i] <= age_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (MODE == 1 && any_gnt) begin
      ptr <= (win_idx == SRC_W'(NUM_SRC - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  // Idle cycles drive an all-zero bus so consumers never see stale payloads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid <= 1'b0;
      cdb_data  <= '0;
      cdb_src   <= '0;
    end else if (any_gnt) begin
      cdb_valid <= 1'b1;
      cdb_data  <= sel_data;
      cdb_src   <= win_idx;
    end else begin
      cdb_valid <= 1'b0;
      cdb_data  <= '0;
      cdb_src   <= '0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: four instances covering the aging, round-robin
// and non-power-of-two configurations, plus flush and mid-stream reset.
module tb_cdb_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // u_p8: MODE0 STARVE_LIMIT=8
  logic        flush_a;
  logic [3:0]  req_a, gnt_a;
  logic [159:0] data_a;
  logic        val_a;
  logic [39:0] cdat_a;
  logic [1:0]  src_a;
  // u_p3: MODE0 STARVE_LIMIT=3
  logic        flush_b;
  logic [3:0]  req_b, gnt_b;
  logic [159:0] data_b;
  logic        val_b;
  logic [39:0] cdat_b;
  logic [1:0]  src_b;
  // u_rr4: MODE1 NUM_SRC=4
  logic        flush_c;
  logic [3:0]  req_c, gnt_c;
  logic [159:0] data_c;
  logic        val_c;
  logic [39:0] cdat_c;
  logic [1:0]  src_c;
  // u_rr3: MODE1 NUM_SRC=3 DATA_W=8
  logic        flush_d;
  logic [2:0]  req_d, gnt_d;
  logic [23:0] data_d;
  logic        val_d;
  logic [7:0]  cdat_d;
  logic [1:0]  src_d;

  cdb_arbiter #(.NUM_SRC(4), .DATA_W(40), .MODE(0), .STARVE_LIMIT(8)) u_p8 (
    .clk(clk), .rst_n(rst_n), .flush(flush_a), .req(req_a), .data(data_a),
    .gnt(gnt_a), .cdb_valid(val_a), .cdb_data(cdat_a), .cdb_src(src_a));

  cdb_arbiter #(.NUM_SRC(4), .DATA_W(40), .MODE(0), .STARVE_LIMIT(3)) u_p3 (
    .clk(clk), .rst_n(rst_n), .flush(flush_b), .req(req_b), .data(data_b),
    .gnt(gnt_b), .cdb_valid(val_b), .cdb_data(cdat_b), .cdb_src(src_b));

  cdb_arbiter #(.NUM_SRC(4), .DATA_W(40), .MODE(1), .STARVE_LIMIT(8)) u_rr4 (
    .clk(clk), .rst_n(rst_n), .flush(flush_c), .req(req_c), .data(data_c),
    .gnt(gnt_c), .cdb_valid(val_c), .cdb_data(cdat_c), .cdb_src(src_c));

  cdb_arbiter #(.NUM_SRC(3), .DATA_W(8), .MODE(1), .STARVE_LIMIT(8)) u_rr3 (
    .clk(clk), .rst_n(rst_n), .flush(flush_d), .req(req_d), .data(data_d),
    .gnt(gnt_d), .cdb_valid(val_d), .cdb_data(cdat_d), .cdb_src(src_d));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] b_gnt [6];
    logic [1:0] b_src [6];
    int         rr_seq [7];
    logic [7:0] d_dat [4];

    b_gnt = '{4'b0001, 4'b0001, 4'b0001, 4'b1000, 4'b0001, 4'b0001};
    b_src = '{2'd0, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0};
    rr_seq = '{0, 1, 2, 3, 0, 1, 2};
    d_dat = '{8'h11, 8'h22, 8'h33, 8'h11};

    flush_a = 0; flush_b = 0; flush_c = 0; flush_d = 0;
    req_a = 4'b1111; req_b = '0; req_c = '0; req_d = '0;
    data_a = {40'd4, 40'd3, 40'd2, 40'd1};
    data_b = {40'hD3, 40'h0, 40'h0, 40'hA0};
    data_c = {40'h44, 40'h33, 40'h22, 40'h11};
    data_d = {8'h33, 8'h22, 8'h11};

    // Reset state, with requests present: gnt must stay low.
    #2;
    check("rst_gnt", 64'(gnt_a), 64'd0);
    check("rst_valid", 64'(val_a), 64'd0);
    check("rst_data", 64'(cdat_a), 64'd0);
    check("rst_src", 64'(src_a), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;

    // MODE0: all requesting, lowest index wins, broadcast next cycle.
    check("m0_gnt_all", 64'(gnt_a), 64'b0001);
    tick();
    req_a = '0;
    check("m0_valid", 64'(val_a), 64'd1);
    check("m0_src", 64'(src_a), 64'd0);
    check("m0_data", 64'(cdat_a), 64'd1);
    #1 check("m0_gnt_idle", 64'(gnt_a), 64'd0);
    tick();
    check("m0_idle_valid", 64'(val_a), 64'd0);
    check("m0_idle_data", 64'(cdat_a), 64'd0);

    // Flush for two cycles with req=0110, then source 1 wins.
    req_a = 4'b0110;
    flush_a = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1 check("fl_gnt", 64'(gnt_a), 64'd0);
      tick();
      check("fl_valid", 64'(val_a), 64'd0);
    end
    flush_a = 1'b0;
    #1 check("fl_gnt_after", 64'(gnt_a), 64'b0010);
    tick();
    req_a = '0;
    check("fl_valid_after", 64'(val_a), 64'd1);
    check("fl_src_after", 64'(src_a), 64'd1);
    check("fl_data_after", 64'(cdat_a), 64'd2);

    // MODE0 aging with STARVE_LIMIT=3, req=1001 held.
    req_b = 4'b1001;
    for (int c = 0; c < 6; c++) begin
      #1 check($sformatf("age_gnt_c%0d", c), 64'(gnt_b), 64'(b_gnt[c]));
      tick();
      check($sformatf("age_src_c%0d", c + 1), 64'(src_b), 64'(b_src[c]));
    end
    req_b = '0;

    // MODE1, four sources, all requesting.
    req_c = 4'b1111;
    for (int c = 0; c < 7; c++) begin
      #1 check($sformatf("rr_gnt_c%0d", c), 64'(gnt_c), 64'(4'b0001 << rr_seq[c]));
      tick();
      check($sformatf("rr_src_c%0d", c), 64'(src_c), 64'(rr_seq[c]));
    end
    // ptr now 3; 0101 wraps to 0, ptr becomes 1 so source 2 is next.
    req_c = 4'b0101;
    #1 check("rr_wrap_gnt", 64'(gnt_c), 64'b0001);
    tick();
    check("rr_wrap_data", 64'(cdat_c), 64'h11);
    #1 check("rr_ptr1_gnt", 64'(gnt_c), 64'b0100);
    tick();
    // Idle cycle leaves ptr at 3.
    req_c = '0;
    tick();
    check("rr_idle_valid", 64'(val_c), 64'd0);
    req_c = 4'b1111;
    #1 check("rr_hold_gnt", 64'(gnt_c), 64'b1000);
    tick();
    req_c = '0;

    // MODE1, three sources, 8-bit payload.
    req_d = 3'b111;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("rr3_src_c%0d", c), 64'(src_d), 64'(c % 3));
      check($sformatf("rr3_data_c%0d", c), 64'(cdat_d), 64'(d_dat[c]));
    end
    req_d = '0;

    // Mid-stream async reset while a broadcast is on the bus.
    data_a = {40'd4, 40'd3, 40'd2, 40'd1};
    req_a = 4'b0100;
    tick();
    check("rs_pre_valid", 64'(val_a), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rs_valid", 64'(val_a), 64'd0);
    check("rs_src", 64'(src_a), 64'd0);
    check("rs_data", 64'(cdat_a), 64'd0);
    check("rs_gnt", 64'(gnt_a), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("rs_first_gnt", 64'(gnt_a), 64'b0100);
    tick();
    check("rs_bus_valid", 64'(val_a), 64'd1);
    check("rs_bus_src", 64'(src_a), 64'd2);
    check("rs_bus_data", 64'(cdat_a), 64'd3);
    req_a = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Parametrised successor to the fixed four-source common data bus. Arbitrates NUM_SRC functional-unit result requests onto one registered broadcast bus with a per-source request/grant handshake. Selectable fixed-priority-with-aging or round-robin policy, plus a flush input for squash. Sits between the functional units (ALU, mul, div, ld/st, …) and every reservation station, register-status and ROB consumer of the CDB.

## Interface
- NUM_SRC, 4: number of requesting sources (≥2); index 0 is highest fixed priority.
- DATA_W, 40: payload width (tag + value).
- MODE, 0: 0 = fixed priority with aging; 1 = round-robin.
- STARVE_LIMIT, 8: wait cycles before a source is aged (MODE 0); 0 disables aging.
- SRC_W (localparam): max(1, clog2(NUM_SRC)).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  squash; suppresses grants and the next broadcast.
- req  in  NUM_SRC  per-source request; held with data until granted.
- data  in  NUM_SRC*DATA_W  source i payload at [i*DATA_W +: DATA_W].
- gnt  out  NUM_SRC  one-hot/zero grant, combinational, same cycle as req.
- cdb_valid  out  1  registered broadcast valid.
- cdb_data  out  DATA_W  registered broadcast payload.
- cdb_src  out  SRC_W  index of the broadcasting source.

## Operation
- Handshake: a source raises req[i] with stable data. It is done when gnt[i]=1 in that cycle. It may drop or change req/data on the following cycle. gnt[i] never asserts without req[i].
- At most one gnt bit per cycle. If any req is set and flush=0 and rst_n=1, exactly one grant issues.
- MODE 0: lowest-index requester wins, unless any source is aged. Aged sources beat non-aged ones; lowest index among aged wins.
- Aging counter per source, width clog2(STARVE_LIMIT+1):
  - +1 each cycle with req & ~gnt.
  - Saturates at STARVE_LIMIT.
  - Clears on gnt, on ~req, or on flush.
  - Aged means counter == STARVE_LIMIT. With STARVE_LIMIT=0 nothing is aged.
- MODE 1: pointer ptr (SRC_W bits). Search starts at ptr, ascending, wrapping modulo NUM_SRC; first requester wins. After a grant to i, ptr <= (i==NUM_SRC-1) ? 0 : i+1. No grant leaves ptr unchanged. Counters are held at 0.
- Broadcast register on the edge ending a grant cycle: cdb_valid<=1, cdb_data<=data[i], cdb_src<=i.
- No grant: cdb_valid<=0, cdb_data<=0, cdb_src<=0. The bus is zeroed when idle.
- flush=1: gnt=0; next edge cdb_valid<=0, cdb_data<=0, cdb_src<=0; counters cleared; ptr held. Requests stay pending and arbitrate after flush drops.

## Timing
- Grant latency: 0 cycles (combinational from req, counters, ptr).
- Broadcast latency: 1 cycle; a grant in cycle t appears on the bus in cycle t+1 for exactly one cycle.
- Throughput: one broadcast per cycle; back-to-back grants to the same or different sources are allowed.
- Reset values (rst_n low, async): cdb_valid=0, cdb_data=0, cdb_src=0, ptr=0, all counters=0. gnt is forced to 0 while rst_n=0.
- Reset mid-operation: any in-flight broadcast is dropped. The first grant occurs in the first cycle with rst_n=1.
- Simultaneous flush and reset: reset dominates.

## Test plan
- MODE0, STARVE_LIMIT=8, req=4'b1111 for one cycle, data_i=i+1. Required: gnt=4'b0001; next cycle cdb_valid=1, cdb_src=0, cdb_data=1.
- MODE0, STARVE_LIMIT=3, req=4'b1001 held continuously, source 0 re-requesting. Required: gnt=0001 in cycles 0–2, gnt=1000 in cycle 3, cdb_src=3 in cycle 4, then source 0 wins again.
- MODE1, NUM_SRC=4, req=4'b1111 continuous. Required: grants 0,1,2,3,0,1. Then, with ptr=3 and req=4'b0101, grant goes to 0 (wrap) and ptr becomes 1.
- MODE1, NUM_SRC=3, DATA_W=8, req=3'b111 continuous. Required: cdb_src sequence 0,1,2,0 (non-power-of-two wrap) and cdb_data 8-bit correct.
- req=4'b0110 with flush=1 for 2 cycles. Required: gnt=0 and cdb_valid=0 during flush plus one cycle; MODE0 grants source 1 in the first cycle after flush drops.
- rst_n pulsed low mid-stream while cdb_valid=1. Required: outputs go to 0 immediately (async); held req=4'b0100 is granted in the first cycle after rst_n=1, and cdb_src=2 appears one cycle later.
